// File: rtl/cpu_job_sequencer.sv
// Job sequencer for the a*b*c program CPU: loads operands into data memory, runs the CPU,
// collects the 16-bit product from words 4/5 and returns it on a valid/ready result port.
module cpu_job_sequencer #(
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic [DW-1:0] job_a,
  input  logic [DW-1:0] job_b,
  input  logic [DW-1:0] job_c,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [15:0]   res_prod,
  output logic          res_timeout,
  output logic          busy,
  output logic          cpu_reset,
  input  logic          cpu_done,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [AW-1:0] AddrA  = AW'(1);
  localparam logic [AW-1:0] AddrB  = AW'(2);
  localparam logic [AW-1:0] AddrC  = AW'(3);
  localparam logic [AW-1:0] AddrHi = AW'(4);
  localparam logic [AW-1:0] AddrLo = AW'(5);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle,
    StWrA,
    StWrB,
    StWrC,
    StRun,
    StRdHi,
    StRdLo,
    StRdWt,
    StResp
  } state_e;

  state_e        state;
  logic [DW-1:0] b_q;
  logic [DW-1:0] c_q;
  logic [CW-1:0] run_cnt;
  logic [7:0]    prod_hi;
  logic [7:0]    rd_byte;

  // Product bytes are always 8 bits wide regardless of the memory word width.
  assign rd_byte = 8'(dm_rdata);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= StIdle;
      job_ready   <= 1'b1;
      res_valid   <= 1'b0;
      res_prod    <= 16'h0000;
      res_timeout <= 1'b0;
      busy        <= 1'b0;
      cpu_reset   <= 1'b1;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      b_q         <= '0;
      c_q         <= '0;
      run_cnt     <= '0;
      prod_hi     <= 8'h00;
    end else begin
      unique case (state)
        StIdle: begin
          if (job_valid && job_ready) begin
            // Operand a goes straight to the write-data register; b and c wait their turn.
            state     <= StWrA;
            job_ready <= 1'b0;
            busy      <= 1'b1;
            dm_we     <= 1'b1;
            dm_addr   <= AddrA;
            dm_wdata  <= job_a;
            b_q       <= job_b;
            c_q       <= job_c;
          end
        end
        StWrA: begin
          state    <= StWrB;
          dm_addr  <= AddrB;
          dm_wdata <= b_q;
        end
        StWrB: begin
          state    <= StWrC;
          dm_addr  <= AddrC;
          dm_wdata <= c_q;
        end
        StWrC: begin
          state     <= StRun;
          dm_we     <= 1'b0;
          dm_addr   <= '0;
          dm_wdata  <= '0;
          cpu_reset <= 1'b0;
          run_cnt   <= '0;
        end
        StRun: begin
          run_cnt <= run_cnt + CW'(1);
          // A done in the first RUN cycle may be stale from the previous job, so skip it.
          if (cpu_done && (run_cnt != '0)) begin
            state     <= StRdHi;
            cpu_reset <= 1'b1;
            dm_addr   <= AddrHi;
          end else if (run_cnt == CntLast) begin
            state       <= StResp;
            cpu_reset   <= 1'b1;
            res_valid   <= 1'b1;
            res_prod    <= 16'h0000;
            res_timeout <= 1'b1;
          end
        end
        StRdHi: begin
          state   <= StRdLo;
          dm_addr <= AddrLo;
        end
        StRdLo: begin
          state   <= StRdWt;
          prod_hi <= rd_byte;
          dm_addr <= '0;
        end
        StRdWt: begin
          state       <= StResp;
          res_valid   <= 1'b1;
          res_prod    <= {prod_hi, rd_byte};
          res_timeout <= 1'b0;
        end
        StResp: begin
          if (res_ready) begin
            state     <= StIdle;
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= StIdle;
          job_ready <= 1'b1;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          cpu_reset <= 1'b1;
          dm_we     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_job_sequencer.sv
// Bench for cpu_job_sequencer: bench-side data memory plus a behavioural CPU stub,
// a table of directed jobs, randomized jobs against a reference model, and a mid-job reset.
module tb_cpu_job_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        job_valid;
  logic        job_ready;
  logic [7:0]  job_a, job_b, job_c;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_prod;
  logic        res_timeout;
  logic        busy;
  logic        cpu_reset;
  logic        cpu_done;
  logic        dm_we;
  logic [7:0]  dm_addr;
  logic [7:0]  dm_wdata;
  logic [7:0]  dm_rdata = 8'h00;

  always #5 clk = ~clk;

  cpu_job_sequencer #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_a(job_a), .job_b(job_b), .job_c(job_c),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_prod(res_prod), .res_timeout(res_timeout), .busy(busy),
    .cpu_reset(cpu_reset), .cpu_done(cpu_done),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  // Data memory and CPU stub. The sequencer owns the memory port while cpu_reset=1.
  logic [7:0]  mem [256] = '{default: 8'h00};
  logic [15:0] wr_log [$];
  int          run_cyc = 0;
  int          stub_lat = 1000;
  bit          stub_spur = 1'b0;
  bit          stub_pulse = 1'b0;
  bit          stub_ovr = 1'b0;
  logic [15:0] stub_val = 16'h0000;
  logic [15:0] stub_prod;

  function automatic logic [15:0] mul3(input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] z);
    logic [31:0] t;
    t = 32'(x) * 32'(y) * 32'(z);
    return t[15:0];
  endfunction

  assign stub_prod = stub_ovr ? stub_val : mul3(mem[1], mem[2], mem[3]);
  assign cpu_done = !cpu_reset && ((stub_spur && run_cyc == 0) ||
                    (stub_pulse ? (run_cyc == stub_lat) : (run_cyc >= stub_lat)));

  always @(posedge clk) begin
    dm_rdata <= mem[dm_addr];
    if (cpu_reset) begin
      run_cyc <= 0;
      if (dm_we) begin
        mem[dm_addr] <= dm_wdata;
        wr_log.push_back({dm_addr, dm_wdata});
      end
    end else begin
      run_cyc <= run_cyc + 1;
      if (run_cyc == 0) begin
        mem[4] <= stub_prod[15:8];
        mem[5] <= stub_prod[7:0];
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " job_ready"}, job_ready, 1);
    chk({tag, " res_valid"}, res_valid, 0);
    chk({tag, " res_prod"}, res_prod, 0);
    chk({tag, " res_timeout"}, res_timeout, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " cpu_reset"}, cpu_reset, 1);
    chk({tag, " dm_we"}, dm_we, 0);
    chk({tag, " dm_addr"}, dm_addr, 0);
    chk({tag, " dm_wdata"}, dm_wdata, 0);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  a, b, c;
    int          lat;
    bit          spur, pulse, ovr;
    logic [15:0] ovr_val;
    int          hold;
    logic [15:0] exp_prod;
    bit          exp_to;
    int          exp_cyc;
  } vec_t;

  function automatic vec_t mk(input string name, input int a, input int b, input int c,
                              input int lat, input bit spur, input bit pulse, input bit ovr,
                              input int ovr_val, input int hold, input int exp_prod,
                              input bit exp_to, input int exp_cyc);
    vec_t v;
    v.name = name; v.a = 8'(a); v.b = 8'(b); v.c = 8'(c);
    v.lat = lat; v.spur = spur; v.pulse = pulse; v.ovr = ovr; v.ovr_val = 16'(ovr_val);
    v.hold = hold; v.exp_prod = 16'(exp_prod); v.exp_to = exp_to; v.exp_cyc = exp_cyc;
    return v;
  endfunction

  // Reference: first honoured done is RUN cycle max(lat,1); RUN starts 4 cycles after accept,
  // result 4 cycles after done, or timeout after TO RUN cycles.
  function automatic vec_t ref_job(input string name, input int a, input int b, input int c,
                                   input int lat, input bit spur, input int hold);
    int eff;
    vec_t v;
    eff = (lat < 1) ? 1 : lat;
    if (eff <= int'(TO) - 1) v = mk(name, a, b, c, lat, spur, 0, 0, 0, hold,
                                    (a * b * c) % 65536, 0, 4 + eff + 4);
    else v = mk(name, a, b, c, lat, spur, 0, 0, 0, hold, 0, 1, 4 + int'(TO));
    return v;
  endfunction

  // Called at a negedge; returns at a negedge with the sequencer back in IDLE.
  task automatic do_job(input vec_t v);
    int n;
    logic [7:0] ops [3];
    ops[0] = v.a; ops[1] = v.b; ops[2] = v.c;
    stub_lat = v.lat; stub_spur = v.spur; stub_pulse = v.pulse;
    stub_ovr = v.ovr; stub_val = v.ovr_val;
    wr_log.delete();
    job_a = v.a; job_b = v.b; job_c = v.c; job_valid = 1'b1;
    chk({v.name, " job_ready"}, job_ready, 1);
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
    n = 1;
    while (!res_valid && n < 64) begin
      if (n == 4) chk({v.name, " cpu_reset in RUN"}, cpu_reset, 0);
      if (!v.exp_to && n == v.exp_cyc - 3) chk({v.name, " dm_addr RD_HI"}, dm_addr, 4);
      if (!v.exp_to && n == v.exp_cyc - 2) chk({v.name, " dm_addr RD_LO"}, dm_addr, 5);
      @(negedge clk);
      n++;
    end
    chk({v.name, " res_valid"}, res_valid, 1);
    chk({v.name, " latency"}, n, v.exp_cyc);
    chk({v.name, " res_prod"}, res_prod, v.exp_prod);
    chk({v.name, " res_timeout"}, res_timeout, v.exp_to);
    chk({v.name, " writes"}, wr_log.size(), 3);
    for (int i = 0; i < 3; i++)
      chk({v.name, " write entry"}, (i < wr_log.size()) ? wr_log[i] : 16'hxxxx,
          {8'(i + 1), ops[i]});
    job_valid = (v.hold > 0);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk({v.name, " hold res_valid"}, res_valid, 1);
      chk({v.name, " hold res_prod"}, res_prod, v.exp_prod);
      chk({v.name, " hold job_ready"}, job_ready, 0);
      chk({v.name, " hold busy"}, busy, 1);
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk({v.name, " idle res_valid"}, res_valid, 0);
    chk({v.name, " idle job_ready"}, job_ready, 1);
    chk({v.name, " idle busy"}, busy, 0);
    chk({v.name, " idle cpu_reset"}, cpu_reset, 1);
  endtask

  vec_t tbl [9];

  initial begin
    int n;
    tbl[0] = mk("t1 2*3*4",      2,   3,   4,    5, 0, 0, 0, 0,       0, 16'h0018, 0, 13);
    tbl[1] = mk("t2 12*14*4",   12,  14,   4,    3, 0, 0, 0, 0,       0, 16'h02A0, 0, 11);
    tbl[2] = mk("t3 never done", 9,   9,   9, 1000, 0, 0, 0, 0,       0, 16'h0000, 1, 20);
    tbl[3] = mk("t4 pulse done", 1,   1,   1,    2, 1, 1, 1, 16'h02FF, 0, 16'h02FF, 0, 10);
    tbl[4] = mk("t5 hold",       5,   7,   9,    4, 0, 0, 0, 0,      10, 16'h013B, 0, 12);
    tbl[5] = mk("max operands", 255, 255, 255,   1, 1, 0, 0, 0,       1, 16'h02FF, 0, 9);
    tbl[6] = mk("done at last",  7,   9,  11,   15, 0, 0, 0, 0,       0, 16'h02B5, 0, 23);
    tbl[7] = mk("one too late",  7,   9,  11,   16, 0, 0, 0, 0,       0, 16'h0000, 1, 20);
    tbl[8] = mk("wrap 100^3",  100, 100, 100,    4, 0, 0, 0, 0,       2, 16'h4240, 0, 12);

    reset = 1'b0; job_valid = 1'b0; res_ready = 1'b0;
    job_a = 8'h00; job_b = 8'h00; job_c = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;

    foreach (tbl[i]) do_job(tbl[i]);

    for (int i = 0; i < 40; i++)
      do_job(ref_job("random", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, TO + 4)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 3))));

    // Reset mid-RUN with job_valid held, then a fresh job right after release.
    stub_lat = 10; stub_spur = 0; stub_pulse = 0; stub_ovr = 0;
    job_a = 8'd5; job_b = 8'd6; job_c = 8'd7; job_valid = 1'b1;
    @(posedge clk);
    repeat (6) @(negedge clk);
    chk("t6 in RUN cpu_reset", cpu_reset, 0);
    #2 reset = 1'b0;
    #1 chk_reset_vals("t6 async reset");
    @(negedge clk);
    chk_reset_vals("t6 held reset");
    stub_lat = 2;
    job_a = 8'd3; job_b = 8'd5; job_c = 8'd7;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
    chk("t6 accept dm_we", dm_we, 1);
    chk("t6 accept dm_addr", dm_addr, 1);
    chk("t6 accept dm_wdata", dm_wdata, 3);
    chk("t6 accept busy", busy, 1);
    n = 1;
    while (!res_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("t6 res_valid", res_valid, 1);
    chk("t6 latency", n, 10);
    chk("t6 res_prod", res_prod, 105);
    chk("t6 res_timeout", res_timeout, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("t6 back to idle", job_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
